// File: rtl/cnt_hex7seg_scan.sv
// -----------------------------------------------------------------------------
// cnt_hex7seg_scan
//   Shows an 8-bit value as two hex digits on a time-multiplexed 7-segment
//   display. Samples arrive over a valid/ready handshake and wait in a one-entry
//   shadow register. The shadow moves into the display register only at a frame
//   boundary, so a single frame never mixes digits from two different values.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   value_i         8-bit sample from the counter stage
//   value_valid_i   value_i is valid
//   value_ready_o   shadow register empty, a sample can be accepted
//   seg_o           segments, bit0 = a .. bit6 = g
//   dp_o            decimal point, lit in the low digit for one frame after an update
//   digit_sel_o     one-hot digit select, bit0 = low nibble, bit1 = high nibble
//
// Build option:
//   CNT_DISP_ZERO_BLANK_EN  when defined, the high digit is blanked whenever its
//                           nibble is zero (select and timing are unchanged)
// -----------------------------------------------------------------------------
module cnt_hex7seg_scan #(
    parameter int unsigned SCAN_DIV       = 1024, // clocks per digit, 1..65535
    parameter int unsigned GAP_CYCLES     = 2,    // blanking clocks after each digit, 1..255
    parameter bit          SEG_ACTIVE_LOW = 1'b0  // 1: seg_o/dp_o are active low
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value_i,
    input  logic       value_valid_i,
    output logic       value_ready_o,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [1:0] digit_sel_o
);
    // Purpose: two-digit hex scanner with a one-entry shadow register.
    // Latency: an accepted value is displayed from the next frame boundary (up to one frame).
    // Backpressure: ready is low while the shadow is full; it reopens at the frame boundary.

    typedef enum logic [1:0] {
        ST_DIG0 = 2'd0,
        ST_GAP0 = 2'd1,
        ST_DIG1 = 2'd2,
        ST_GAP1 = 2'd3
    } state_t;

    localparam logic [15:0] DIG_LAST = 16'(SCAN_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] tick_q;
    logic        last_tick;
    logic        frame_edge;

    logic [7:0]  shadow_q;
    logic        shadow_full_q;
    logic [7:0]  disp_q;
    logic        fresh_q;
    logic        xfer;

    logic [6:0]  seg_lvl;
    logic        dp_lvl;
    logic [1:0]  sel;

    // Glyph table, bit order gfedcba, 1 = segment lit.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Digit states run SCAN_DIV clocks, blanking states GAP_CYCLES clocks.
    always_comb begin
        last_tick = 1'b0;
        case (state_q)
            ST_DIG0, ST_DIG1: last_tick = (tick_q == DIG_LAST);
            default:          last_tick = (tick_q == GAP_LAST);
        endcase
    end

    // State register; the tick counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_GAP1;
            tick_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            if (last_tick) begin
                tick_q <= 16'd0;
            end else begin
                tick_q <= tick_q + 16'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (last_tick) begin
            case (state_q)
                ST_DIG0: state_d = ST_GAP0;
                ST_GAP0: state_d = ST_DIG1;
                ST_DIG1: state_d = ST_GAP1;
                default: state_d = ST_DIG0;
            endcase
        end
    end

    // The GAP1 -> DIG0 edge is the only point where the display may change.
    assign frame_edge    = (state_q == ST_GAP1) && last_tick;
    assign value_ready_o = !shadow_full_q;
    assign xfer          = value_valid_i && value_ready_o;

    // Shadow/display datapath. While the shadow is full ready is low, so a
    // transfer and a shadow drain can never happen on the same edge. A transfer
    // landing on a boundary with an empty shadow stays in the shadow until the
    // following boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= 8'h00;
            shadow_full_q <= 1'b0;
            disp_q        <= 8'h00;
            fresh_q       <= 1'b0;
        end else begin
            if (frame_edge) begin
                if (shadow_full_q) begin
                    disp_q        <= shadow_q;
                    shadow_full_q <= 1'b0;
                    fresh_q       <= 1'b1;
                end else begin
                    fresh_q <= 1'b0;
                end
            end
            if (xfer) begin
                shadow_q      <= value_i;
                shadow_full_q <= 1'b1;
            end
        end
    end

    // Output decode from registered state only; levels here are active high.
    always_comb begin
        sel     = 2'b00;
        seg_lvl = 7'h00;
        dp_lvl  = 1'b0;
        case (state_q)
            ST_DIG0: begin
                sel     = 2'b01;
                seg_lvl = hex_font(disp_q[3:0]);
                dp_lvl  = fresh_q;
            end
            ST_DIG1: begin
                sel     = 2'b10;
                seg_lvl = hex_font(disp_q[7:4]);
`ifdef CNT_DISP_ZERO_BLANK_EN
                if (disp_q[7:4] == 4'h0) begin
                    seg_lvl = 7'h00;
                end
`endif
            end
            default: begin
                sel     = 2'b00;
                seg_lvl = 7'h00;
                dp_lvl  = 1'b0;
            end
        endcase
    end

    // Physical polarity; digit select is always active high.
    assign digit_sel_o = sel;
    assign seg_o       = seg_lvl ^ {7{SEG_ACTIVE_LOW}};
    assign dp_o        = dp_lvl ^ SEG_ACTIVE_LOW;

endmodule

// File: doc/cnt_hex7seg_scan.md
Name: cnt_hex7seg_scan

Overview:
- Downstream consumer of the free-running 8-bit counter value.
- Accepts 8-bit samples over a valid/ready handshake and stages each one in a shadow register.
- Time-multiplexes the value as two hex digits onto a shared 7-segment bus with one-hot digit select and inter-digit blanking.
- New values load into the display only at frame boundaries, so a frame never shows mixed digits.

Parameters:
SCAN_DIV, 1024, clocks each digit is driven per frame; legal range 1..65535.
GAP_CYCLES, 2, all-off blanking clocks after each digit (anti-ghosting); legal range 1..255.
SEG_ACTIVE_LOW, 0, 1 inverts seg_o and dp_o polarity; digit_sel_o is always active high.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
value_i  input  8  sample from counter stage
value_valid_i  input  1  value_i is valid
value_ready_o  output  1  shadow register empty, can accept
seg_o  output  7  segments, bit0=a .. bit6=g
dp_o  output  1  decimal point; marks a fresh value
digit_sel_o  output  2  one-hot; bit0 = low nibble digit, bit1 = high nibble digit

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All state is flopped on posedge clk.
- Reset state:
  - FSM = GAP1; tick counter = 0.
  - shadow empty, shadow data = 0x00; display reg = 0x00; fresh flag = 0.
  - Outputs during and after reset: value_ready_o = 1, digit_sel_o = 2'b00, segments/dp off.
- FSM cycles DIG0 -> GAP0 -> DIG1 -> GAP1 -> DIG0.
  - DIG states last SCAN_DIV clocks; GAP states last GAP_CYCLES clocks.
  - Tick counter clears on every state change.
  - Frame length = 2*(SCAN_DIV+GAP_CYCLES) clocks.
- Outputs are decoded combinationally from the registered state and display reg:
  - DIG0: digit_sel_o = 01, seg = font(display[3:0]).
  - DIG1: digit_sel_o = 10, seg = font(display[7:4]).
  - GAP0/GAP1: digit_sel_o = 00, segments and dp off.
- Font (gfedcba):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- "Off" means physical level 0 when SEG_ACTIVE_LOW=0 and level 1 when SEG_ACTIVE_LOW=1. The same inversion applies to lit segments.
- Handshake:
  - Transfer occurs when value_valid_i & value_ready_o at a clock edge.
  - value_ready_o = !shadow_full, registered-state driven, with no combinational path from value_valid_i.
  - On transfer: shadow <= value_i, shadow_full <= 1.
  - Upstream holds value_i stable while valid and not ready; the block never drops an accepted value.
- Frame boundary = the clock edge where GAP1 -> DIG0.
  - If shadow_full: display <= shadow, shadow_full <= 0, fresh <= 1.
  - Otherwise: display unchanged, fresh <= 0.
- Simultaneous boundary and transfer while shadow is empty: the new value enters the shadow and displays at the NEXT boundary.
- Multiple values offered within one frame: only the first is accepted; ready stays low until the boundary.
- dp_o is lit only in DIG0 while fresh = 1, i.e. for one frame after an update.
- Reset asserted mid-frame returns everything immediately (asynchronously) to the reset state. A pending shadow value is discarded.

Optional Feature:
- Macro CNT_DISP_ZERO_BLANK_EN.
- Defined: in DIG1, if display[7:4] == 0, segments are off. digit_sel_o still = 10 and timing is unchanged.
- Undefined: the high digit always shows its glyph, including '0' (3F).

Test Plan:
- Setup for all scenarios: SCAN_DIV=4, GAP_CYCLES=2 (frame = 12 clocks).
- Reset release, no valid -> after 2 GAP1 clocks: DIG0 for 4 clocks, digit_sel=01, seg=3F, dp=0; then 2 clocks sel=00; then DIG1 sel=10, seg=3F. value_ready_o=1 throughout.
- Offer 0xA7 during the first GAP1 -> ready drops the next cycle; at the boundary DIG0 shows seg=07, dp=1; DIG1 shows seg=77; ready returns to 1. In the following frame dp=0.
- Offer 0x12 mid-DIG1, then 0x34 one cycle later with valid held -> 0x12 accepted; 0x34 stalls (ready=0) until after the boundary, then is accepted and displayed one frame later.
- Valid asserted exactly on the GAP1 -> DIG0 edge with shadow empty -> current frame keeps the old value; the new value appears at the next boundary.
- Assert rst_n low mid-DIG1 with shadow full -> outputs go off/00 immediately, value_ready_o=1; after release the display shows 0x00 and the stored value is lost.
- SEG_ACTIVE_LOW=1, value 0x0F -> DIG0 seg=0x0E, gaps seg=0x7F and dp=1. With CNT_DISP_ZERO_BLANK_EN defined, DIG1 seg=0x7F (off); undefined, DIG1 seg=0x40.
